alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single clocked 8-bit alu between two requesters. Arbitrates round-robin and issues one op at a time.
//  Sequences an optional 16-bit "wide" op as two chained ALU passes (low byte, then high byte with carry-in = low cout).
//  Returns a 16-bit result and flags with a one-cycle ack per requester. Sits between the requesters and the alu instance.
// PARAMETERS
//  ALU_LAT  1       cycles from alu input change to valid alu_y/flags (registered ALU = 1); legal 1..7
//  IDLE_OP  3'b100  alu_op driven while no operation is in flight
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  req0/req1  in   1   request; hold high, operands stable, until matching ack
//  a0/a1      in   16  operand A; narrow ops use [7:0]
//  b0/b1      in   16  operand B; narrow ops use [7:0]
//  op0/op1    in   3   alu opcode, passed through unchanged
//  cin0/cin1  in   1   carry-in for (low) pass
//  wide0/wide1 in  1   1 = 16-bit two-pass op
//  ack0/ack1  out  1   one-cycle pulse: result valid for that requester
//  y          out  16  result; narrow: {8'h00, y_lo}
//  cout,ovf,neg out 1  flags; wide: from high pass
//  zero       out  1   narrow: alu zero; wide: zero_lo & zero_hi
//  busy       out  1   high in any state except IDLE
//  gnt_id     out  1   requester currently/last served
//  alu_a,alu_b out 8   to alu
//  alu_op     out  3   to alu
//  alu_cin    out  1   to alu
//  alu_y      in   8   from alu
//  alu_cout,alu_ovf,alu_zero,alu_neg in 1 from alu
// BEHAVIOUR
//  Reset: state IDLE; ack0=ack1=0; y=0; all flags 0; busy=0; gnt_id=0; rr priority to req0.
//  Reset: alu_a=alu_b=0, alu_cin=0, alu_op=IDLE_OP.
//  Reset mid-operation aborts with no ack; the in-flight result is discarded.
//  FSM IDLE -> LO -> [HI] -> DONE -> IDLE.
//  IDLE: if any req, pick winner via round-robin; latch operands, op, cin and wide; set gnt_id; go to LO.
//  IDLE with no req: alu inputs held at idle values.
//  Round-robin: if both req, the requester not served last wins; if one req, it wins. Reset favours 0.
//  LO: drive alu_a=a[7:0], alu_b=b[7:0], alu_op=op, alu_cin=cin. Wait counter 0..ALU_LAT.
//  LO at count==ALU_LAT: capture y_lo, cout_lo, zero_lo; go to HI if wide, else DONE.
//  HI: drive a[15:8], b[15:8], op, alu_cin=cout_lo. At count==ALU_LAT capture y_hi and flags; go to DONE.
//  DONE: ack of gnt_id high for exactly this cycle; y and flags valid from this cycle until the next DONE.
//  Latency (req sampled in IDLE at cycle N):
//    narrow ack at N+2+ALU_LAT (N+3 for ALU_LAT=1)
//    wide ack at N+3+2*ALU_LAT (N+5 for ALU_LAT=1)
//  Back-to-back: requesters drop req on the edge after ack, so the following IDLE cycle re-arbitrates.
//  Minimum issue interval: ALU_LAT+3 cycles (narrow).
//  A req held high through IDLE after its ack is a new request.
//  A req dropped before ack is ignored: the op completes and ack is still pulsed.
//  Request and operand changes while busy do not affect the in-flight op.
//  Counter width is 3 bits; no wrap, because it resets on every state entry.
// STRUCTURE
//  alu_ctrl_defs.vh: state encodings (S_IDLE,S_LO,S_HI,S_DONE), IDLE_OP default, CNT_W=3.
//  Sub-module rr_arb2: 2-way round-robin grant with last-served pointer, updated only on IDLE issue.
//  Top: FSM, operand/result registers, alu mux.
// TESTING
//  Bench uses a behavioural ALU stub with ALU_LAT register stages; op 3'b000 = ADC (a+b+cin), with flags.
//  1. req0 narrow a=8'h0F b=8'h01 cin=0 op=000 -> ack0 at N+3, y=16'h0010, cout=0, zero=0.
//  2. req1 wide a=16'h00FF b=16'h0001 cin=0 -> HI pass alu_cin=1; ack1 at N+5, y=16'h0100, zero=0, cout=0.
//  3. Wide a=16'hFFFF b=16'h0001 -> y=16'h0000, zero=1, cout=1.
//  4. req0 and req1 both held for 4 ops -> grant order 0,1,0,1; one ack per op; never both acks in one cycle.
//  5. rst pulsed in LO of a wide op -> no ack; next cycle busy=0, alu_op=3'b100, y=0; req1 then served first-priority-0 rules.
//  6. ALU_LAT=3, narrow op -> ack at N+5; alu inputs stable through all LO cycles.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, the latched request record and a byte-select helper.
package alu_arbiter_pkg;

    localparam int          CNT_W       = 3;
    localparam logic [2:0]  IDLE_OP_DEF = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        cin;
        logic        wide;
    } req_t;

    function automatic logic [7:0] op_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester.
// The requester holds req and operands stable until it sees ack.
interface alu_arbiter_if;

    logic        req;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        cin;
    logic        wide;
    logic        ack;

    modport master (output req, a, b, op, cin, wide, input  ack);
    modport slave  (input  req, a, b, op, cin, wide, output ack);

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-served pointer moves only when an op is issued.
// After reset the pointer names requester 1, so requester 0 wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_issue,
    output logic       o_win
);

    logic r_last;
    logic w_win;

    always_comb begin
        // NOTE: default first so every path assigns w_win and no latch is inferred.
        w_win = 1'b0;
        case (i_req)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_issue) begin
            r_last <= w_win;
        end
    end

    assign o_win = w_win;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked 8-bit ALU between two requesters, one op at a time.
// Wide ops run as a low pass then a high pass chained through the low carry-out.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter logic [2:0]  IDLE_OP = IDLE_OP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      i_rq0,
    alu_arbiter_if.slave      i_rq1,
    output logic [15:0]       o_y,
    output logic              o_cout,
    output logic              o_ovf,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_busy,
    output logic              o_gnt_id,
    output logic [7:0]        o_alu_a,
    output logic [7:0]        o_alu_b,
    output logic [2:0]        o_alu_op,
    output logic              o_alu_cin,
    input  logic [7:0]        i_alu_y,
    input  logic              i_alu_cout,
    input  logic              i_alu_ovf,
    input  logic              i_alu_zero,
    input  logic              i_alu_neg
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    req_t               r_req;
    logic               r_gnt_id;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_busy;
    logic [15:0]        r_y;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;
    logic [7:0]         r_y_lo;
    logic               r_zero_lo;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [2:0]         r_alu_op;
    logic               r_alu_cin;

    req_t               w_req0;
    req_t               w_req1;
    req_t               w_cand;
    logic               w_win;
    logic               w_issue;
    logic               w_lat_hit;

    assign w_req0 = '{a: i_rq0.a, b: i_rq0.b, op: i_rq0.op, cin: i_rq0.cin, wide: i_rq0.wide};
    assign w_req1 = '{a: i_rq1.a, b: i_rq1.b, op: i_rq1.op, cin: i_rq1.cin, wide: i_rq1.wide};
    assign w_cand    = w_win ? w_req1 : w_req0;
    assign w_issue   = (r_state == S_IDLE) && (i_rq0.req || i_rq1.req);
    assign w_lat_hit = (r_cnt == CNT_W'(ALU_LAT));

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   ({i_rq1.req, i_rq0.req}),
        .i_issue (w_issue),
        .o_win   (w_win)
    );

    // NOTE: all state here uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_req     <= '0;
            r_gnt_id  <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_busy    <= 1'b0;
            r_y       <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_y_lo    <= '0;
            r_zero_lo <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= IDLE_OP;
            r_alu_cin <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req     <= w_cand;
                        r_gnt_id  <= w_win;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_LO;
                        r_alu_a   <= op_byte(w_cand.a, 1'b0);
                        r_alu_b   <= op_byte(w_cand.b, 1'b0);
                        r_alu_op  <= w_cand.op;
                        r_alu_cin <= w_cand.cin;
                    end else begin
                        r_alu_a   <= '0;
                        r_alu_b   <= '0;
                        r_alu_op  <= IDLE_OP;
                        r_alu_cin <= 1'b0;
                    end
                end
                S_LO: begin
                    if (w_lat_hit) begin
                        r_y_lo    <= i_alu_y;
                        r_zero_lo <= i_alu_zero;
                        r_cnt     <= '0;
                        if (r_req.wide) begin
                            // High pass chains the low carry-out straight into the ALU.
                            r_state   <= S_HI;
                            r_alu_a   <= op_byte(r_req.a, 1'b1);
                            r_alu_b   <= op_byte(r_req.b, 1'b1);
                            r_alu_cin <= i_alu_cout;
                        end else begin
                            r_state <= S_DONE;
                            r_y     <= {8'h00, i_alu_y};
                            r_cout  <= i_alu_cout;
                            r_ovf   <= i_alu_ovf;
                            r_zero  <= i_alu_zero;
                            r_neg   <= i_alu_neg;
                            r_ack0  <= ~r_gnt_id;
                            r_ack1  <= r_gnt_id;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HI: begin
                    if (w_lat_hit) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        r_y     <= {i_alu_y, r_y_lo};
                        r_cout  <= i_alu_cout;
                        r_ovf   <= i_alu_ovf;
                        r_zero  <= r_zero_lo & i_alu_zero;
                        r_neg   <= i_alu_neg;
                        r_ack0  <= ~r_gnt_id;
                        r_ack1  <= r_gnt_id;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_alu_a   <= '0;
                    r_alu_b   <= '0;
                    r_alu_op  <= IDLE_OP;
                    r_alu_cin <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign i_rq0.ack = r_ack0;
    assign i_rq1.ack = r_ack1;
    assign o_y       = r_y;
    assign o_cout    = r_cout;
    assign o_ovf     = r_ovf;
    assign o_zero    = r_zero;
    assign o_neg     = r_neg;
    assign o_busy    = r_busy;
    assign o_gnt_id  = r_gnt_id;
    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;
    assign o_alu_op  = r_alu_op;
    assign o_alu_cin = r_alu_cin;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each driving a behavioural registered ALU stub; a select flag routes stimulus to one of them.
module tb_alu_arbiter;

    typedef struct packed {
        logic [7:0] y;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
    } alu_res_t;

    typedef struct {
        logic        who;
        logic        wide;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        cin;
        logic [15:0] ey;
        logic        ec;
        logic        eo;
        logic        ez;
        logic        en;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        s_sel3;
    logic        s_req0, s_req1;
    logic [15:0] s_a0, s_b0, s_a1, s_b1;
    logic [2:0]  s_op0, s_op1;
    logic        s_cin0, s_cin1, s_wide0, s_wide1;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter_if u_if1_0 ();
    alu_arbiter_if u_if1_1 ();
    alu_arbiter_if u_if3_0 ();
    alu_arbiter_if u_if3_1 ();

    assign u_if1_0.req = s_req0 & ~s_sel3;  assign u_if3_0.req = s_req0 & s_sel3;
    assign u_if1_1.req = s_req1 & ~s_sel3;  assign u_if3_1.req = s_req1 & s_sel3;
    assign u_if1_0.a = s_a0;  assign u_if1_0.b = s_b0;  assign u_if1_0.op = s_op0;
    assign u_if1_0.cin = s_cin0;  assign u_if1_0.wide = s_wide0;
    assign u_if3_0.a = s_a0;  assign u_if3_0.b = s_b0;  assign u_if3_0.op = s_op0;
    assign u_if3_0.cin = s_cin0;  assign u_if3_0.wide = s_wide0;
    assign u_if1_1.a = s_a1;  assign u_if1_1.b = s_b1;  assign u_if1_1.op = s_op1;
    assign u_if1_1.cin = s_cin1;  assign u_if1_1.wide = s_wide1;
    assign u_if3_1.a = s_a1;  assign u_if3_1.b = s_b1;  assign u_if3_1.op = s_op1;
    assign u_if3_1.cin = s_cin1;  assign u_if3_1.wide = s_wide1;

    logic [15:0] d1_y, d3_y;
    logic        d1_cout, d1_ovf, d1_zero, d1_neg, d1_busy, d1_gnt, d1_alu_cin;
    logic        d3_cout, d3_ovf, d3_zero, d3_neg, d3_busy, d3_gnt, d3_alu_cin;
    logic [7:0]  d1_alu_a, d1_alu_b, d3_alu_a, d3_alu_b;
    logic [2:0]  d1_alu_op, d3_alu_op;
    alu_res_t    st1;
    alu_res_t    st3 [3];

    alu_arbiter #(.ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_rq0(u_if1_0), .i_rq1(u_if1_1),
        .o_y(d1_y), .o_cout(d1_cout), .o_ovf(d1_ovf), .o_zero(d1_zero), .o_neg(d1_neg),
        .o_busy(d1_busy), .o_gnt_id(d1_gnt),
        .o_alu_a(d1_alu_a), .o_alu_b(d1_alu_b), .o_alu_op(d1_alu_op), .o_alu_cin(d1_alu_cin),
        .i_alu_y(st1.y), .i_alu_cout(st1.cout), .i_alu_ovf(st1.ovf),
        .i_alu_zero(st1.zero), .i_alu_neg(st1.neg)
    );

    alu_arbiter #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_rq0(u_if3_0), .i_rq1(u_if3_1),
        .o_y(d3_y), .o_cout(d3_cout), .o_ovf(d3_ovf), .o_zero(d3_zero), .o_neg(d3_neg),
        .o_busy(d3_busy), .o_gnt_id(d3_gnt),
        .o_alu_a(d3_alu_a), .o_alu_b(d3_alu_b), .o_alu_op(d3_alu_op), .o_alu_cin(d3_alu_cin),
        .i_alu_y(st3[2].y), .i_alu_cout(st3[2].cout), .i_alu_ovf(st3[2].ovf),
        .i_alu_zero(st3[2].zero), .i_alu_neg(st3[2].neg)
    );

    wire        w_ack0  = s_sel3 ? u_if3_0.ack : u_if1_0.ack;
    wire        w_ack1  = s_sel3 ? u_if3_1.ack : u_if1_1.ack;
    wire [15:0] w_y     = s_sel3 ? d3_y : d1_y;
    wire [3:0]  w_flags = s_sel3 ? {d3_cout, d3_ovf, d3_zero, d3_neg} : {d1_cout, d1_ovf, d1_zero, d1_neg};
    wire        w_busy  = s_sel3 ? d3_busy : d1_busy;
    wire        w_gnt   = s_sel3 ? d3_gnt : d1_gnt;
    wire [7:0]  w_alu_a = s_sel3 ? d3_alu_a : d1_alu_a;
    wire [7:0]  w_alu_b = s_sel3 ? d3_alu_b : d1_alu_b;
    wire [2:0]  w_alu_op  = s_sel3 ? d3_alu_op : d1_alu_op;
    wire        w_alu_cin = s_sel3 ? d3_alu_cin : d1_alu_cin;

    // Behavioural ALU: 000 add-with-carry, 001 AND, 010 OR, 011 XOR, else pass A.
    function automatic alu_res_t alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic cin);
        alu_res_t   r;
        logic [8:0] s;
        r = '0;
        s = '0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                r.y = s[7:0];
                r.cout = s[8];
                r.ovf = (a[7] == b[7]) && (r.y[7] != a[7]);
            end
            3'b001:  r.y = a & b;
            3'b010:  r.y = a | b;
            3'b011:  r.y = a ^ b;
            default: r.y = a;
        endcase
        r.zero = (r.y == 8'h00);
        r.neg = r.y[7];
        return r;
    endfunction

    always @(posedge clk) begin
        st1    <= alu_model(d1_alu_a, d1_alu_b, d1_alu_op, d1_alu_cin);
        st3[0] <= alu_model(d3_alu_a, d3_alu_b, d3_alu_op, d3_alu_cin);
        st3[1] <= st3[0];
        st3[2] <= st3[1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int   cyc;
        logic seen, other, busy_ok, my_ack;
        @(posedge clk); #1;
        if (v.who == 1'b0) begin
            s_a0 = v.a; s_b0 = v.b; s_op0 = v.op; s_cin0 = v.cin; s_wide0 = v.wide; s_req0 = 1'b1;
        end else begin
            s_a1 = v.a; s_b1 = v.b; s_op1 = v.op; s_cin1 = v.cin; s_wide1 = v.wide; s_req1 = 1'b1;
        end
        cyc = 0; seen = 1'b0; other = 1'b0; busy_ok = 1'b0;
        while (!seen && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) busy_ok = w_busy;
            my_ack = v.who ? w_ack1 : w_ack0;
            other  = other | (v.who ? w_ack0 : w_ack1);
            if (my_ack) seen = 1'b1;
        end
        check({tag, "_acked"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(v.lat));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_other_ack"}, 32'(other), 32'd0);
        check({tag, "_y"}, 32'(w_y), 32'(v.ey));
        check({tag, "_flags_cozn"}, 32'(w_flags), 32'({v.ec, v.eo, v.ez, v.en}));
        check({tag, "_gnt_id"}, 32'(w_gnt), 32'(v.who));
        @(posedge clk); #1;
        check({tag, "_ack_one_cycle"}, 32'(v.who ? w_ack1 : w_ack0), 32'd0);
        s_req0 = 1'b0;
        s_req1 = 1'b0;
    endtask

    vec_t vecs [9];
    vec_t vec3 [2];

    initial begin
        int       cyc, nacks, both, first_ack, second_ack;
        logic     seen, stable, bad;
        logic [3:0] order;

        vecs[0] = '{1'b0, 1'b0, 16'h000F, 16'h0001, 3'b000, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b1, 1'b1, 16'h00FF, 16'h0001, 3'b000, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        vecs[3] = '{1'b1, 1'b0, 16'h007F, 16'h0001, 3'b000, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        vecs[4] = '{1'b0, 1'b0, 16'h00FF, 16'h00FF, 3'b000, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b1, 3};
        vecs[5] = '{1'b1, 1'b0, 16'h1234, 16'h5678, 3'b000, 1'b0, 16'h00AC, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        vecs[6] = '{1'b0, 1'b1, 16'h1280, 16'h0180, 3'b000, 1'b1, 16'h1401, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vecs[7] = '{1'b1, 1'b0, 16'h00F0, 16'h000F, 3'b001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[8] = '{1'b0, 1'b1, 16'h0001, 16'h0000, 3'b000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vec3[0] = '{1'b1, 1'b0, 16'h0003, 16'h0004, 3'b000, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vec3[1] = '{1'b0, 1'b1, 16'h00FF, 16'h0001, 3'b000, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 9};

        rst = 1'b1; s_sel3 = 1'b0; s_req0 = 1'b0; s_req1 = 1'b0;
        s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0; s_op0 = '0; s_op1 = '0;
        s_cin0 = 1'b0; s_cin1 = 1'b0; s_wide0 = 1'b0; s_wide1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_ack", 32'({w_ack0, w_ack1}), 32'd0);
        check("rst_y", 32'(w_y), 32'd0);
        check("rst_flags", 32'(w_flags), 32'd0);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_gnt", 32'(w_gnt), 32'd0);
        check("rst_alu_op", 32'(w_alu_op), 32'h4);
        check("rst_alu_ab_cin", 32'({w_alu_a, w_alu_b, w_alu_cin}), 32'd0);

        // Wide op: watch the ALU inputs for both passes and the carry chaining
        @(posedge clk); #1;
        s_a1 = 16'h00FF; s_b1 = 16'h0001; s_op1 = 3'b000; s_cin1 = 1'b0; s_wide1 = 1'b1; s_req1 = 1'b1;
        @(posedge clk); #1;
        check("wseq_lo_ab", 32'({w_alu_a, w_alu_b}), 32'h0000FF01);
        check("wseq_lo_op_cin", 32'({w_alu_op, w_alu_cin}), 32'h0);
        check("wseq_gnt", 32'(w_gnt), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wseq_hi_ab", 32'({w_alu_a, w_alu_b}), 32'h0);
        check("wseq_hi_cin", 32'(w_alu_cin), 32'd1);
        check("wseq_hi_no_ack", 32'(w_ack1), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wseq_ack_n5", 32'(w_ack1), 32'd1);
        check("wseq_y", 32'(w_y), 32'h0100);
        @(posedge clk); #1;
        s_req1 = 1'b0;
        check("wseq_idle_alu_op", 32'(w_alu_op), 32'h4);
        check("wseq_idle_busy", 32'(w_busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i], $sformatf("v%0d", i));
        end

        // Request dropped and operands changed mid-op: original op still completes
        @(posedge clk); #1;
        s_a1 = 16'h0021; s_b1 = 16'h0011; s_op1 = 3'b000; s_cin1 = 1'b0; s_wide1 = 1'b0; s_req1 = 1'b1;
        @(posedge clk); #1;
        s_req1 = 1'b0; s_a1 = 16'h00FF; s_b1 = 16'h00FF; s_cin1 = 1'b1;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (w_ack1) seen = 1'b1;
        end
        check("drop_acked", 32'(seen), 32'd1);
        check("drop_latency", 32'(cyc), 32'd3);
        check("drop_y", 32'(w_y), 32'h0032);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drop_no_reissue", 32'(w_busy), 32'd0);

        // Both requesters held: strict alternation starting at 0 after reset
        do_reset();
        s_a0 = 16'h0001; s_b0 = 16'h0001; s_op0 = 3'b000; s_cin0 = 1'b0; s_wide0 = 1'b0;
        s_a1 = 16'h0010; s_b1 = 16'h0020; s_op1 = 3'b000; s_cin1 = 1'b0; s_wide1 = 1'b0;
        s_req0 = 1'b1; s_req1 = 1'b1;
        nacks = 0; both = 0; order = '0; cyc = 0; first_ack = 0; second_ack = 0;
        while (nacks < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (w_ack0 && w_ack1) both++;
            if (w_ack0 || w_ack1) begin
                order[nacks] = w_ack1;
                check("rr_y", 32'(w_y), w_ack1 ? 32'h0030 : 32'h0002);
                if (nacks == 0) first_ack = cyc;
                if (nacks == 1) second_ack = cyc;
                nacks++;
            end
        end
        check("rr_ack_count", 32'(nacks), 32'd4);
        check("rr_order", 32'(order), 32'b1010);
        check("rr_both_acks", 32'(both), 32'd0);
        check("rr_issue_interval", 32'(second_ack - first_ack), 32'd4);
        @(posedge clk); #1;
        s_req0 = 1'b0; s_req1 = 1'b0;

        // Reset in the LO pass of a wide op
        @(posedge clk); #1;
        s_a0 = 16'h00FF; s_b0 = 16'h0001; s_op0 = 3'b000; s_cin0 = 1'b0; s_wide0 = 1'b1; s_req0 = 1'b1;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(w_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_req0 = 1'b0;
        check("abort_busy", 32'(w_busy), 32'd0);
        check("abort_alu_op", 32'(w_alu_op), 32'h4);
        check("abort_y", 32'(w_y), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bad = bad | w_ack0 | w_ack1 | w_busy;
        end
        check("abort_no_ack", 32'(bad), 32'd0);
        s_a0 = 16'h0005; s_b0 = 16'h0003; s_wide0 = 1'b0; s_req0 = 1'b1;
        s_a1 = 16'h0040; s_b1 = 16'h0002; s_wide1 = 1'b0; s_req1 = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (w_ack0 || w_ack1) seen = 1'b1;
        end
        check("post_rst_first_is_0", 32'({w_ack1, w_ack0}), 32'b01);
        check("post_rst_y0", 32'(w_y), 32'h0008);
        @(posedge clk); #1;
        s_req0 = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (w_ack1) seen = 1'b1;
        end
        check("post_rst_req1_served", 32'(seen), 32'd1);
        check("post_rst_y1", 32'(w_y), 32'h0042);
        @(posedge clk); #1;
        s_req1 = 1'b0;

        // ALU_LAT=3 instance
        s_sel3 = 1'b1;
        do_reset();
        @(posedge clk); #1;
        s_a0 = 16'h000F; s_b0 = 16'h0001; s_op0 = 3'b000; s_cin0 = 1'b0; s_wide0 = 1'b0; s_req0 = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            stable = stable && (w_alu_a == 8'h0F) && (w_alu_b == 8'h01) &&
                     (w_alu_op == 3'b000) && !w_alu_cin && !w_ack0;
        end
        check("lat3_lo_inputs_stable", 32'(stable), 32'd1);
        @(posedge clk); #1;
        check("lat3_ack_n5", 32'(w_ack0), 32'd1);
        check("lat3_y", 32'(w_y), 32'h0010);
        @(posedge clk); #1;
        s_req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            do_op(vec3[i], $sformatf("l3v%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
